// File: rtl/_pipe_stage.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer and a registered in_ready.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt backpressure counter.
module _pipe_stage #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    input  logic         flush
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e         r_state;
    state_e         w_state_d;
    logic [n-1:0]   r_main;
    logic [n-1:0]   w_main_d;
    logic [n-1:0]   r_skid;
    logic [n-1:0]   w_skid_d;
    logic           r_in_ready;
    logic           w_in_xfer;
    logic           w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_state[0] & out_ready;

    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;
        if (flush) begin
            // Data registers keep their contents; only the valid bits drop.
            w_state_d = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_xfer) begin
                        w_main_d  = in_data;
                        w_state_d = StOne;
                    end
                end
                StOne: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_d = in_data;
                    end else if (w_in_xfer) begin
                        w_skid_d  = in_data;
                        w_state_d = StFull;
                    end else if (w_out_xfer) begin
                        w_state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (w_out_xfer) begin
                        w_main_d  = r_skid;
                        w_state_d = StOne;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_main     <= w_main_d;
            r_skid     <= w_skid_d;
            r_in_ready <= ~w_state_d[1];
        end
    end

    assign out_valid = r_state[0];
    assign out_data  = r_main;
    assign in_ready  = r_in_ready;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state[0] && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
